multi_mode_ff_bank: RTL and testbench

- Clocked, parametrised successor to the team's gate-level SR/JK/D latch cells.
- Provides WIDTH independent storage channels. Each channel is configured at runtime as an SR, JK, D or T flip-flop.
- Adds per-channel illegal-input detection (SR with S=R=1) and a per-channel change pulse.
- Used wherever control logic needs a bank of configurable edge-triggered state bits instead of free-running cross-coupled gates.

---
 rtl/ff_bank_pkg.sv | 41 ++++
 rtl/ff_bank_cell.sv | 58 +++++
 rtl/multi_mode_ff_bank.sv | 54 +++++
 tb/tb_multi_mode_ff_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// Shared mode encoding and per-channel next-state rule for the configurable flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  // Returns {q_next, illegal}; a is R/K/D/T and b is S/J.
  function automatic logic [1:0] ff_next(mode_e mode, logic a, logic b, logic q);
    logic q_n;
    logic ill;
    q_n = q;
    ill = 1'b0;
    case (mode)
      MODE_SR: begin
        case ({b, a})
          2'b10:   q_n = 1'b1;
          2'b01:   q_n = 1'b0;
          2'b11:   ill = 1'b1;
          default: q_n = q;
        endcase
      end
      MODE_JK: begin
        case ({b, a})
          2'b10:   q_n = 1'b1;
          2'b01:   q_n = 1'b0;
          2'b11:   q_n = ~q;
          default: q_n = q;
        endcase
      end
      MODE_D:  q_n = a;
      MODE_T:  q_n = q ^ a;
      default: q_n = q;
    endcase
    return {q_n, ill};
  endfunction

endpackage

// File: rtl/ff_bank_cell.sv
// One storage channel: mode register, state flop, change pulse and sticky illegal-input flag.
module ff_bank_cell
  import ff_bank_pkg::*;
#(
  parameter logic  RESET_Q    = 1'b0,
  parameter mode_e RESET_MODE = MODE_D
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  a,
  input  logic  b,
  input  logic  cfg_load,
  input  mode_e cfg_mode,
  input  logic  err_clr,
  output logic  q,
  output logic  chg,
  output logic  err,
  output mode_e mode
);

  logic  q_q, q_d;
  logic  chg_q, chg_d;
  logic  err_q, err_d;
  mode_e mode_q, mode_d;
  logic  q_nxt;
  logic  illegal;

  always_comb begin
    {q_nxt, illegal} = ff_next(mode_q, a, b, q_q);
    // Disabled channels ignore a/b entirely, including for illegal detection.
    q_d    = en ? q_nxt : q_q;
    chg_d  = (q_d != q_q);
    err_d  = (en & illegal) | (err_q & ~err_clr);
    // Data path above uses mode_q, so a same-cycle write only takes effect next edge.
    mode_d = cfg_load ? cfg_mode : mode_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RESET_Q;
      chg_q  <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= RESET_MODE;
    end else begin
      q_q    <= q_d;
      chg_q  <= chg_d;
      err_q  <= err_d;
      mode_q <= mode_d;
    end
  end

  assign q    = q_q;
  assign chg  = chg_q;
  assign err  = err_q;
  assign mode = mode_q;

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH independent flip-flops, each runtime-configurable as SR, JK, D or T.
module multi_mode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned          WIDTH      = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL  = {WIDTH{1'b0}},
  parameter logic [1:0]           RESET_MODE = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cfg_we,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic [1:0]           cfg_mode,
  input  logic [WIDTH-1:0]     err_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [WIDTH-1:0]     chg,
  output logic [WIDTH-1:0]     err,
  output logic [2*WIDTH-1:0]   mode_o
);

  mode_e cfg_mode_e;
  assign cfg_mode_e = mode_e'(cfg_mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    mode_e cell_mode;

    ff_bank_cell #(
      .RESET_Q    (RESET_VAL[i]),
      .RESET_MODE (mode_e'(RESET_MODE))
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .a        (a[i]),
      .b        (b[i]),
      .cfg_load (cfg_we & cfg_mask[i]),
      .cfg_mode (cfg_mode_e),
      .err_clr  (err_clr[i]),
      .q        (q[i]),
      .chg      (chg[i]),
      .err      (err[i]),
      .mode     (cell_mode)
    );

    assign mode_o[2*i +: 2] = cell_mode;
  end

  assign qn = ~q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Randomised and directed self-checking bench with a behavioural model of the flip-flop bank.
module tb_multi_mode_ff_bank;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   en, a, b, cfg_mask, err_clr;
  logic           cfg_we;
  logic [1:0]     cfg_mode;
  logic [W-1:0]   q, qn, chg, err;
  logic [2*W-1:0] mode_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [W-1:0] mq, mchg, merr;
  logic [1:0]   mmode [W];

  multi_mode_ff_bank #(
    .WIDTH      (W),
    .RESET_VAL  (RV),
    .RESET_MODE (2'b10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (a),
    .b        (b),
    .cfg_we   (cfg_we),
    .cfg_mask (cfg_mask),
    .cfg_mode (cfg_mode),
    .err_clr  (err_clr),
    .q        (q),
    .qn       (qn),
    .chg      (chg),
    .err      (err),
    .mode_o   (mode_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: characteristic equations per flip-flop type.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq   <= RV;
      mchg <= '0;
      merr <= '0;
      for (int i = 0; i < W; i++) mmode[i] <= 2'd2;
    end else begin
      for (int i = 0; i < W; i++) begin
        logic nq;
        logic ill;
        nq  = mq[i];
        ill = 1'b0;
        if (en[i]) begin
          case (mmode[i])
            2'd0: if (b[i] && a[i]) ill = 1'b1; else nq = b[i] | (~a[i] & mq[i]);
            2'd1: nq = (b[i] & ~mq[i]) | (~a[i] & mq[i]);
            2'd2: nq = a[i];
            default: nq = mq[i] ^ a[i];
          endcase
        end
        mq[i]   <= nq;
        mchg[i] <= (nq != mq[i]);
        merr[i] <= ill | (merr[i] & ~err_clr[i]);
        if (cfg_we && cfg_mask[i]) mmode[i] <= cfg_mode;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] mpack;
      for (int i = 0; i < W; i++) mpack[2*i +: 2] = mmode[i];
      chk("q", {8'h0, q}, {8'h0, mq});
      chk("qn", {8'h0, qn}, {8'h0, ~mq});
      chk("chg", {8'h0, chg}, {8'h0, mchg});
      chk("err", {8'h0, err}, {8'h0, merr});
      chk("mode_o", mode_o, mpack);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    en = '0; a = '0; b = '0; cfg_we = 1'b0; cfg_mask = '0; cfg_mode = 2'd0; err_clr = '0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_q", {8'h0, q}, 16'h00A5);
    chk("rst_qn", {8'h0, qn}, 16'h005A);
    chk("rst_mode", mode_o, 16'hAAAA);
    chk("rst_err", {8'h0, err}, 16'h0000);
    chk("rst_chg", {8'h0, chg}, 16'h0000);

    // D load on all channels.
    en = 8'hFF; a = 8'h3C;
    tick();
    idle();
    chk("d_q", {8'h0, q}, 16'h003C);
    chk("d_chg", {8'h0, chg}, 16'h0099);

    // Channel 0 to SR, illegal S=R=1.
    cfg_we = 1'b1; cfg_mask = 8'h01; cfg_mode = 2'b00;
    tick();
    idle();
    en = 8'h01; a = 8'h01; b = 8'h01;
    tick();
    chk("sr_ill_q", {8'h0, q}, 16'h003C);
    chk("sr_ill_err", {8'h0, err}, 16'h0001);
    chk("sr_ill_chg", {8'h0, chg}, 16'h0000);
    err_clr = 8'h01;
    tick();
    chk("sr_set_wins", {8'h0, err}, 16'h0001);
    a = '0; b = '0;
    tick();
    chk("sr_clr", {8'h0, err}, 16'h0000);
    idle();

    // Channel 1 to JK, toggle for 4 edges from 0.
    cfg_we = 1'b1; cfg_mask = 8'h02; cfg_mode = 2'b01;
    tick();
    idle();
    en = 8'h02; a = 8'h02; b = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("jk_q1", {15'h0, q[1]}, {15'h0, ~k[0]});
      chk("jk_chg1", {15'h0, chg[1]}, 16'h0001);
    end
    idle();

    // Channel 2: clear, then same-cycle mode write uses the old D rule.
    en = 8'h04; a = 8'h00;
    tick();
    chk("d2_clear", {15'h0, q[2]}, 16'h0000);
    cfg_we = 1'b1; cfg_mask = 8'h04; cfg_mode = 2'b11; a = 8'h04;
    tick();
    chk("d2_old_mode", {15'h0, q[2]}, 16'h0001);
    cfg_we = 1'b0; cfg_mask = '0;
    tick();
    chk("t2_toggle", {15'h0, q[2]}, 16'h0000);
    idle();

    // Channel 3 in SR with en low: illegal inputs ignored.
    cfg_we = 1'b1; cfg_mask = 8'h08; cfg_mode = 2'b00;
    tick();
    idle();
    a = 8'h08; b = 8'h08;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en0_q3", {15'h0, q[3]}, 16'h0001);
      chk("en0_chg3", {15'h0, chg[3]}, 16'h0000);
      chk("en0_err3", {15'h0, err[3]}, 16'h0000);
    end
    idle();

    // All channels to T and toggle, then asynchronous reset mid-cycle.
    cfg_we = 1'b1; cfg_mask = 8'hFF; cfg_mode = 2'b11;
    tick();
    idle();
    en = 8'hFF; a = 8'hFF;
    tick();
    tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", {8'h0, q}, 16'h00A5);
    chk("arst_mode", mode_o, 16'hAAAA);
    chk("arst_chg", {8'h0, chg}, 16'h0000);
    tick();
    rst = 1'b0;
    chk("rel_q", {8'h0, q}, 16'h00A5);
    chk("rel_chg", {8'h0, chg}, 16'h0000);
    tick();
    chk("rel_d_load", {8'h0, q}, 16'h00FF);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      en       = W'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_mask = W'($urandom);
      cfg_mode = 2'($urandom_range(0, 3));
      err_clr  = W'($urandom) & W'($urandom);
      if (k == 200) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
